// File: rtl/park_pkg.sv
// Shared definitions for the parking exit controller: FSM state encoding and
// the clog2-derived widths used by the top and the slot table.
package park_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_RESULT = 2'd2,
    ST_LOCKED = 2'd3
  } park_state_e;

  localparam int DEF_NUM_SLOTS = 8;

  function automatic int token_w(input int slots);
    return (slots < 2) ? 1 : $clog2(slots);
  endfunction

  function automatic int cnt_w(input int slots);
    return $clog2(slots + 1);
  endfunction

endpackage

// File: rtl/park_slot_table.sv
// Per-slot occupancy and stored exit pattern, with entry write port, release
// (clear) port, lookup port and a running count of free slots.
module park_slot_table
  import park_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int PATTERN_W = 3,
  parameter int TOKEN_W   = token_w(DEF_NUM_SLOTS),
  parameter int CNT_W     = cnt_w(DEF_NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_req,
  input  logic [TOKEN_W-1:0]   wr_token,
  input  logic [PATTERN_W-1:0] wr_pattern,
  output logic                 wr_ok,
  input  logic                 clr_en,
  input  logic [TOKEN_W-1:0]   clr_token,
  input  logic [TOKEN_W-1:0]   rd_token,
  output logic                 rd_occupied,
  output logic [PATTERN_W-1:0] rd_pattern,
  output logic [CNT_W-1:0]     free_count
);

  localparam logic [TOKEN_W:0] SLOT_LIMIT = (TOKEN_W + 1)'(NUM_SLOTS);

  logic [NUM_SLOTS-1:0] occupied;
  logic [PATTERN_W-1:0] pattern_mem [NUM_SLOTS];
  logic                 wr_in_range;
  logic                 rd_in_range;

  assign wr_in_range = ({1'b0, wr_token} < SLOT_LIMIT);
  assign rd_in_range = ({1'b0, rd_token} < SLOT_LIMIT);
  // A slot being released this cycle still reads occupied, so entry to it is refused.
  assign wr_ok       = wr_req && wr_in_range && !occupied[wr_token];

  // Lookup port; out-of-range tokens read as an empty slot.
  always_comb begin
    rd_occupied = 1'b0;
    rd_pattern  = '0;
    if (rd_in_range) begin
      rd_occupied = occupied[rd_token];
      rd_pattern  = pattern_mem[rd_token];
    end else begin
      rd_occupied = 1'b0;
      rd_pattern  = '0;
    end
  end

  // Occupancy and pattern storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupied <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        pattern_mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        occupied[wr_token]    <= 1'b1;
        pattern_mem[wr_token] <= wr_pattern;
      end
      if (clr_en) begin
        occupied[clr_token] <= 1'b0;
      end
    end
  end

  // Free-slot counter; an entry and a release in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_count <= CNT_W'(NUM_SLOTS);
    end else begin
      case ({wr_ok, clr_en})
        2'b10:   free_count <= free_count - CNT_W'(1);
        2'b01:   free_count <= free_count + CNT_W'(1);
        default: free_count <= free_count;
      endcase
    end
  end

endmodule

// File: rtl/park_exit_ctrl.sv
// Parking exit controller: slot registration and pattern-checked exit with a
// fixed two-cycle result latency. Build macro PARK_LOCKOUT_EN enables lockout.
module park_exit_ctrl
  import park_pkg::*;
#(
  parameter int NUM_SLOTS   = 8,
  parameter int PATTERN_W   = 3,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16,
  localparam int TOKEN_W    = token_w(NUM_SLOTS),
  localparam int CNT_W      = cnt_w(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enter_valid,
  input  logic [TOKEN_W-1:0]   enter_token,
  input  logic [PATTERN_W-1:0] enter_pattern,
  output logic                 enter_err,
  input  logic                 exit_valid,
  output logic                 exit_ready,
  input  logic [TOKEN_W-1:0]   exit_token,
  input  logic [PATTERN_W-1:0] exit_pattern,
  output logic                 result_valid,
  output logic                 result_grant,
  output logic [NUM_SLOTS-1:0] park_location,
  output logic [CNT_W-1:0]     free_count,
  output logic                 locked
);

  localparam int               FAIL_W   = $clog2(MAX_FAIL + 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_FAIL);

  park_state_e          state;
  park_state_e          next_state;
  logic [TOKEN_W-1:0]   cap_token;
  logic [PATTERN_W-1:0] cap_pattern;
  logic [FAIL_W-1:0]    fail_cnt;
  logic [FAIL_W-1:0]    fail_next;
  logic                 accept;
  logic                 check_grant;
  logic                 wr_ok;
  logic                 rd_occupied;
  logic [PATTERN_W-1:0] rd_pattern;
  logic                 clr_en;

  assign accept      = exit_valid && exit_ready;
  assign check_grant = rd_occupied && (rd_pattern == cap_pattern);
  assign clr_en      = (state == ST_RESULT) && result_grant;

  park_slot_table #(
    .NUM_SLOTS (NUM_SLOTS),
    .PATTERN_W (PATTERN_W),
    .TOKEN_W   (TOKEN_W),
    .CNT_W     (CNT_W)
  ) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (enter_valid),
    .wr_token    (enter_token),
    .wr_pattern  (enter_pattern),
    .wr_ok       (wr_ok),
    .clr_en      (clr_en),
    .clr_token   (cap_token),
    .rd_token    (cap_token),
    .rd_occupied (rd_occupied),
    .rd_pattern  (rd_pattern),
    .free_count  (free_count)
  );

`ifdef PARK_LOCKOUT_EN
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  logic [LOCK_W-1:0] lock_timer;

  // Lockout timer: loaded on entry to LOCKED, counts down to the exit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_timer <= '0;
    end else if ((state == ST_RESULT) && (next_state == ST_LOCKED)) begin
      lock_timer <= LOCK_W'(LOCK_CYCLES - 1);
    end else if ((state == ST_LOCKED) && (lock_timer != '0)) begin
      lock_timer <= lock_timer - LOCK_W'(1);
    end else begin
      lock_timer <= lock_timer;
    end
  end

  // Registered lockout flag, aligned with the LOCKED state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
    end else begin
      locked <= (next_state == ST_LOCKED);
    end
  end
`else
  assign locked = 1'b0;
`endif

  // Next-state and fail-counter update.
  always_comb begin
    next_state = state;
    fail_next  = fail_cnt;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          next_state = ST_CHECK;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_CHECK: begin
        next_state = ST_RESULT;
      end
      ST_RESULT: begin
        if (result_grant) begin
          fail_next = '0;
        end else if (fail_cnt < FAIL_MAX) begin
          fail_next = fail_cnt + FAIL_W'(1);
        end else begin
          fail_next = fail_cnt;
        end
`ifdef PARK_LOCKOUT_EN
        if (!result_grant && (fail_next == FAIL_MAX)) begin
          next_state = ST_LOCKED;
        end else begin
          next_state = ST_IDLE;
        end
`else
        next_state = ST_IDLE;
`endif
      end
      ST_LOCKED: begin
`ifdef PARK_LOCKOUT_EN
        if (lock_timer == '0) begin
          next_state = ST_IDLE;
          fail_next  = '0;
        end else begin
          next_state = ST_LOCKED;
        end
`else
        next_state = ST_IDLE;
`endif
      end
      default: begin
        next_state = ST_IDLE;
        fail_next  = '0;
      end
    endcase
  end

  // State, fail counter and captured exit request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fail_cnt    <= '0;
      cap_token   <= '0;
      cap_pattern <= '0;
    end else begin
      state    <= next_state;
      fail_cnt <= fail_next;
      if (accept) begin
        cap_token   <= exit_token;
        cap_pattern <= exit_pattern;
      end
    end
  end

  // Registered outputs; the result is decided in CHECK and presented in RESULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exit_ready    <= 1'b1;
      result_valid  <= 1'b0;
      result_grant  <= 1'b0;
      park_location <= '0;
      enter_err     <= 1'b0;
    end else begin
      exit_ready   <= (next_state == ST_IDLE);
      result_valid <= (state == ST_CHECK);
      result_grant <= (state == ST_CHECK) && check_grant;
      if ((state == ST_CHECK) && check_grant) begin
        park_location <= NUM_SLOTS'(1) << cap_token;
      end else begin
        park_location <= '0;
      end
      enter_err <= enter_valid && !wr_ok;
    end
  end

endmodule

// File: tb/tb_park_exit_ctrl.sv
// Directed self-checking bench for park_exit_ctrl (default parameters).
module tb_park_exit_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enter_valid;
  logic [2:0] enter_token;
  logic [2:0] enter_pattern;
  logic       enter_err;
  logic       exit_valid;
  logic       exit_ready;
  logic [2:0] exit_token;
  logic [2:0] exit_pattern;
  logic       result_valid;
  logic       result_grant;
  logic [7:0] park_location;
  logic [3:0] free_count;
  logic       locked;

  int checks = 0;
  int errors = 0;

  park_exit_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enter_valid   (enter_valid),
    .enter_token   (enter_token),
    .enter_pattern (enter_pattern),
    .enter_err     (enter_err),
    .exit_valid    (exit_valid),
    .exit_ready    (exit_ready),
    .exit_token    (exit_token),
    .exit_pattern  (exit_pattern),
    .result_valid  (result_valid),
    .result_grant  (result_grant),
    .park_location (park_location),
    .free_count    (free_count),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_enter(input logic [2:0] tok, input logic [2:0] pat);
    enter_valid   = 1'b1;
    enter_token   = tok;
    enter_pattern = pat;
    tick();
    enter_valid   = 1'b0;
  endtask

  // Returns one cycle after the accept edge (controller in CHECK).
  task automatic do_exit(input logic [2:0] tok, input logic [2:0] pat);
    int n;
    n            = 0;
    exit_valid   = 1'b1;
    exit_token   = tok;
    exit_pattern = pat;
    while (!exit_ready && n < 40) begin
      tick();
      n++;
    end
    check_eq("exit_accept_wait", {31'd0, exit_ready}, 32'd1);
    tick();
    exit_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    enter_valid   = 1'b0;
    enter_token   = 3'd0;
    enter_pattern = 3'd0;
    exit_valid    = 1'b0;
    exit_token    = 3'd0;
    exit_pattern  = 3'd0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_exit_ready", {31'd0, exit_ready}, 32'd1);
    check_eq("rst_result_valid", {31'd0, result_valid}, 32'd0);
    check_eq("rst_result_grant", {31'd0, result_grant}, 32'd0);
    check_eq("rst_park_location", {24'd0, park_location}, 32'd0);
    check_eq("rst_enter_err", {31'd0, enter_err}, 32'd0);
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_free_count", {28'd0, free_count}, 32'd8);

    // Enter slot 4 and exit it with the right pattern.
    do_enter(3'd4, 3'b110);
    check_eq("s1_enter_err", {31'd0, enter_err}, 32'd0);
    check_eq("s1_free_after_enter", {28'd0, free_count}, 32'd7);
    do_exit(3'd4, 3'b110);
    check_eq("s1_rv_early", {31'd0, result_valid}, 32'd0);
    check_eq("s1_busy_ready", {31'd0, exit_ready}, 32'd0);
    tick();
    check_eq("s1_result_valid", {31'd0, result_valid}, 32'd1);
    check_eq("s1_result_grant", {31'd0, result_grant}, 32'd1);
    check_eq("s1_park_location", {24'd0, park_location}, 32'h10);
    tick();
    check_eq("s1_rv_after", {31'd0, result_valid}, 32'd0);
    check_eq("s1_loc_after", {24'd0, park_location}, 32'd0);
    check_eq("s1_free_after_exit", {28'd0, free_count}, 32'd8);
    check_eq("s1_ready_after", {31'd0, exit_ready}, 32'd1);

    // Wrong pattern on slot 5 is denied and the slot stays occupied.
    do_enter(3'd5, 3'b101);
    check_eq("s2_free_after_enter", {28'd0, free_count}, 32'd7);
    do_exit(3'd5, 3'b100);
    tick();
    check_eq("s2_result_valid", {31'd0, result_valid}, 32'd1);
    check_eq("s2_result_grant", {31'd0, result_grant}, 32'd0);
    check_eq("s2_park_location", {24'd0, park_location}, 32'd0);
    tick();
    check_eq("s2_free_unchanged", {28'd0, free_count}, 32'd7);
    do_enter(3'd5, 3'b000);
    check_eq("s2_slot5_still_occ", {31'd0, enter_err}, 32'd1);

    // Double entry on slot 2.
    do_enter(3'd2, 3'b001);
    check_eq("s3_first_err", {31'd0, enter_err}, 32'd0);
    check_eq("s3_first_free", {28'd0, free_count}, 32'd6);
    do_enter(3'd2, 3'b010);
    check_eq("s3_second_err", {31'd0, enter_err}, 32'd1);
    check_eq("s3_second_free", {28'd0, free_count}, 32'd6);
    tick();
    check_eq("s3_err_one_cycle", {31'd0, enter_err}, 32'd0);

    // Grant on slot 3 with a colliding entry to slot 3 in the RESULT cycle.
    do_enter(3'd3, 3'b011);
    check_eq("s4_free_after_enter", {28'd0, free_count}, 32'd5);
    do_exit(3'd3, 3'b011);
    tick();
    check_eq("s4_result_grant", {31'd0, result_grant}, 32'd1);
    check_eq("s4_park_location", {24'd0, park_location}, 32'h08);
    do_enter(3'd3, 3'b111);
    check_eq("s4_collide_err", {31'd0, enter_err}, 32'd1);
    check_eq("s4_free_after_release", {28'd0, free_count}, 32'd6);
    do_enter(3'd3, 3'b111);
    check_eq("s4_slot3_was_free", {31'd0, enter_err}, 32'd0);
    check_eq("s4_free_reentry", {28'd0, free_count}, 32'd5);

    // Three consecutive denials on empty slot 7.
    for (int i = 0; i < 3; i++) begin
      do_exit(3'd7, 3'b000);
      tick();
      check_eq("s5_deny_valid", {31'd0, result_valid}, 32'd1);
      check_eq("s5_deny_grant", {31'd0, result_grant}, 32'd0);
      tick();
    end
`ifdef PARK_LOCKOUT_EN
    for (int k = 0; k < 16; k++) begin
      check_eq("s5_locked", {31'd0, locked}, 32'd1);
      check_eq("s5_locked_ready", {31'd0, exit_ready}, 32'd0);
      tick();
    end
    check_eq("s5_unlock_ready", {31'd0, exit_ready}, 32'd1);
    check_eq("s5_unlocked", {31'd0, locked}, 32'd0);
`else
    check_eq("s5_no_lock", {31'd0, locked}, 32'd0);
    check_eq("s5_ready_no_lock", {31'd0, exit_ready}, 32'd1);
`endif
    do_exit(3'd5, 3'b101);
    tick();
    check_eq("s5_grant_after", {31'd0, result_grant}, 32'd1);
    check_eq("s5_loc_after", {24'd0, park_location}, 32'h20);
    tick();
    check_eq("s5_free_after", {28'd0, free_count}, 32'd6);

    // Reset while the controller is in CHECK.
    do_exit(3'd2, 3'b001);
    rst_n = 1'b0;
    #2;
    check_eq("s6_rv_in_reset", {31'd0, result_valid}, 32'd0);
    check_eq("s6_free_in_reset", {28'd0, free_count}, 32'd8);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check_eq("s6_no_result", {31'd0, result_valid}, 32'd0);
      tick();
    end
    check_eq("s6_grant", {31'd0, result_grant}, 32'd0);
    check_eq("s6_loc", {24'd0, park_location}, 32'd0);
    check_eq("s6_enter_err", {31'd0, enter_err}, 32'd0);
    check_eq("s6_locked", {31'd0, locked}, 32'd0);
    check_eq("s6_ready", {31'd0, exit_ready}, 32'd1);
    check_eq("s6_free", {28'd0, free_count}, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/park_exit_ctrl.md
PARK_EXIT_CTRL -- requirements
Module: park_exit_ctrl

Interface
REQ-001 Parameter NUM_SLOTS, default 8: number of parking slots; legal range 2..64.
REQ-002 Parameter PATTERN_W, default 3: width of the exit pattern (password).
REQ-003 Parameter MAX_FAIL, default 3: consecutive denied exits that trigger lockout.
REQ-004 Parameter LOCK_CYCLES, default 16: lockout duration in clk cycles.
REQ-005 Derived TOKEN_W = clog2(NUM_SLOTS), CNT_W = clog2(NUM_SLOTS+1).
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 enter_valid  input  1  request to register a car into a slot.
REQ-009 enter_token  input  TOKEN_W  slot index for entry.
REQ-010 enter_pattern  input  PATTERN_W  pattern stored for that slot.
REQ-011 enter_err  output  1  one-cycle pulse: entry rejected.
REQ-012 exit_valid  input  1  exit request; held until accepted.
REQ-013 exit_ready  output  1  high only in IDLE and not locked.
REQ-014 exit_token  input  TOKEN_W  slot index for exit.
REQ-015 exit_pattern  input  PATTERN_W  pattern offered at exit.
REQ-016 result_valid  output  1  one-cycle pulse carrying exit outcome.
REQ-017 result_grant  output  1  1 = exit granted, 0 = denied; meaningful with result_valid.
REQ-018 park_location  output  NUM_SLOTS  one-hot released slot during granted result_valid, else all-zero (never Z).
REQ-019 free_count  output  CNT_W  number of unoccupied slots.
REQ-020 locked  output  1  high while lockout active.

Function
REQ-021 Per-slot state SHALL be occupied bit plus stored pattern.
REQ-022 Exit handshake SHALL accept when exit_valid and exit_ready in same cycle; token/pattern captured then.
REQ-023 FSM states SHALL be IDLE, CHECK, RESULT, LOCKED; IDLE->CHECK on accept, CHECK->RESULT next cycle, RESULT->IDLE or LOCKED next cycle.
REQ-024 Latency SHALL be fixed: result_valid asserted exactly 2 cycles after accept cycle.
REQ-025 Grant SHALL require slot occupied and stored pattern equal to captured pattern; on grant the occupied bit clears at end of RESULT cycle.
REQ-026 Exit token >= NUM_SLOTS or unoccupied slot SHALL be denied.
REQ-027 Entry SHALL be accepted any cycle when token < NUM_SLOTS and slot free; else enter_err pulses next cycle and table is unchanged.
REQ-028 Entry to the slot being released in the same RESULT cycle SHALL be rejected (table state before release governs).
REQ-029 free_count SHALL update the cycle after each accepted entry or grant; simultaneous entry and grant on different slots leave it unchanged.
REQ-030 Fail counter SHALL increment on each denial, clear on each grant, saturate at MAX_FAIL.

Reset
REQ-031 On rst_n low: FSM IDLE, all slots free, fail counter 0, lock timer 0.
REQ-032 Reset values: exit_ready 1 after release, result_valid 0, result_grant 0, park_location 0, enter_err 0, locked 0, free_count NUM_SLOTS.
REQ-033 Reset mid-transaction SHALL abandon it with no result pulse.

Configuration
REQ-034 Macro PARK_LOCKOUT_EN defined: reaching MAX_FAIL denials moves RESULT->LOCKED for LOCK_CYCLES cycles with locked=1, exit_ready=0, then IDLE with fail counter cleared.
REQ-035 Macro undefined: LOCKED state and lock timer absent, locked tied 0, fail counter still counts but never blocks.

Structure
REQ-036 Shared package park_pkg SHALL hold FSM state enum and clog2-derived width constants.
REQ-037 Sub-module park_slot_table SHALL hold occupied bits, patterns, write/clear ports and free_count.

Verification
REQ-038 Reset, enter token 4 pattern 110 -> free_count 7; exit token 4 pattern 110 -> result_grant 1, park_location 00010000 two cycles after accept, free_count 8.
REQ-039 Enter token 5 pattern 101, exit token 5 pattern 100 -> result_grant 0, park_location 0, slot stays occupied.
REQ-040 With PARK_LOCKOUT_EN, three denials -> locked 1, exit_ready 0 for 16 cycles, then exit_ready 1.
REQ-041 Enter token 2 twice -> second enter_err 1, free_count decremented once.
REQ-042 Grant on token 3 with simultaneous enter on token 3 in RESULT cycle -> enter_err 1, slot 3 free afterward.
REQ-043 rst_n low during CHECK -> no result_valid, all outputs at reset values.
